// File: rtl/ysyx_axi_arb.sv
// Arbitrates IFU fetch, LSU load and LSU store requests onto one AXI4 master port,
// one single-beat transaction at a time, with byte-lane steering for sub-word accesses.
module ysyx_axi_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,

    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,

    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,

    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [63:0]       io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [3:0]        io_master_rid,

    output logic              io_master_awvalid,
    input  logic              io_master_awready,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [3:0]        io_master_awid,
    output logic [7:0]        io_master_awlen,
    output logic [2:0]        io_master_awsize,
    output logic [1:0]        io_master_awburst,

    output logic              io_master_wvalid,
    input  logic              io_master_wready,
    output logic [63:0]       io_master_wdata,
    output logic [7:0]        io_master_wstrb,
    output logic              io_master_wlast,

    input  logic              io_master_bvalid,
    output logic              io_master_bready,
    input  logic [1:0]        io_master_bresp,
    input  logic [3:0]        io_master_bid,

    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_REQ,
        WR_B
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_strb;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_lsu;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic              r_ifu_rvalid;
    logic [DATA_W-1:0] r_lsu_rdata;
    logic              r_lsu_rvalid;
    logic              r_lsu_wready;
    logic              r_bus_err;

    logic              w_done_pulse;
    logic              w_aw_ok;
    logic              w_w_ok;
    logic [2:0]        w_size;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused;

    function automatic logic [2:0] size_of(input logic [7:0] s);
        case (s)
            8'h01:   return 3'd0;
            8'h03:   return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rd_lane(input logic [63:0] d, input logic [2:0] a);
        logic [31:0] w;
        w = a[2] ? d[63:32] : d[31:0];
        return DATA_W'(w >> {a[1:0], 3'b000});
    endfunction

    function automatic logic [63:0] wr_data(input logic [31:0] d, input logic [1:0] o);
        logic [31:0] s;
        s = d << {o, 3'b000};
        return {s, s};
    endfunction

    function automatic logic [7:0] wr_strb(input logic [7:0] s, input logic [2:0] a);
        logic [3:0] n;
        n = s[3:0] << a[1:0];
        return a[2] ? {n, 4'h0} : {4'h0, n};
    endfunction

    // Fetch grants latch strobe 8'h0f, so the size decode yields 2 for them too.
    assign w_size       = size_of(r_strb);
    assign w_rd_word    = rd_lane(io_master_rdata, r_addr[2:0]);
    assign w_done_pulse = r_ifu_rvalid | r_lsu_rvalid | r_lsu_wready;
    assign w_aw_ok      = !r_awvalid || io_master_awready;
    assign w_w_ok       = !r_wvalid || io_master_wready;
    assign w_unused     = &{1'b0, io_master_rid, io_master_bid};

    assign io_master_arvalid = r_arvalid;
    assign io_master_araddr  = r_addr;
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = w_size;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = r_rready;

    assign io_master_awvalid = r_awvalid;
    assign io_master_awaddr  = r_addr;
    assign io_master_awid    = 4'd0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = w_size;
    assign io_master_awburst = 2'b01;

    assign io_master_wvalid  = r_wvalid;
    assign io_master_wdata   = wr_data(32'(r_wdata), r_addr[1:0]);
    assign io_master_wstrb   = wr_strb(r_strb, r_addr[2:0]);
    assign io_master_wlast   = r_wvalid;
    assign io_master_bready  = r_bready;

    assign ifu_rdata  = r_ifu_rdata;
    assign ifu_rvalid = r_ifu_rvalid;
    assign lsu_rdata  = r_lsu_rdata;
    assign lsu_rvalid = r_lsu_rvalid;
    assign lsu_wready = r_lsu_wready;
    assign bus_err    = r_bus_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_strb       <= '0;
            r_wdata      <= '0;
            r_is_lsu     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_ifu_rdata  <= '0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rdata  <= '0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_wready <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_wready <= 1'b0;
            r_ifu_rdata  <= '0;
            r_lsu_rdata  <= '0;
            case (r_state)
                IDLE: begin
                    // A requester still sees its done pulse this cycle and may not
                    // have dropped its request yet, so no grant is taken now.
                    if (!w_done_pulse) begin
                        if (lsu_wvalid) begin
                            r_addr    <= lsu_awaddr;
                            r_strb    <= lsu_wstrb;
                            r_wdata   <= lsu_wdata;
                            r_is_lsu  <= 1'b1;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else if (lsu_arvalid) begin
                            r_addr    <= lsu_araddr;
                            r_strb    <= lsu_rstrb;
                            r_is_lsu  <= 1'b1;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_AR;
                        end else if (ifu_arvalid) begin
                            r_addr    <= ifu_araddr;
                            r_strb    <= 8'h0f;
                            r_is_lsu  <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_AR;
                        end
                    end
                end
                RD_AR: begin
                    if (io_master_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_R;
                    end
                end
                RD_R: begin
                    if (io_master_rvalid) begin
                        if (io_master_rresp != 2'b00) r_bus_err <= 1'b1;
                        if (io_master_rlast) begin
                            r_rready <= 1'b0;
                            if (r_is_lsu) begin
                                r_lsu_rvalid <= 1'b1;
                                r_lsu_rdata  <= w_rd_word;
                            end else begin
                                r_ifu_rvalid <= 1'b1;
                                r_ifu_rdata  <= w_rd_word;
                            end
                            r_state <= IDLE;
                        end
                    end
                end
                WR_REQ: begin
                    if (io_master_awready) r_awvalid <= 1'b0;
                    if (io_master_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (io_master_bvalid) begin
                        if (io_master_bresp != 2'b00) r_bus_err <= 1'b1;
                        r_bready     <= 1'b0;
                        r_lsu_wready <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_axi_arb.sv
// Scoreboard bench for ysyx_axi_arb: a configurable AXI slave responds on the bus,
// expected done pulses are queued at stimulus time and popped as the DUT reports them.
module tb_ysyx_axi_arb;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, lsu_arvalid, lsu_wvalid;
    logic [7:0]  lsu_rstrb, lsu_wstrb;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic        ifu_rvalid, lsu_rvalid, lsu_wready;

    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, awid;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  wstrb;
    logic        bus_err;

    ysyx_axi_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst),
        .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
        .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(4'd0),
        .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst),
        .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
        .io_master_bid(4'd0),
        .bus_err(bus_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: kind 0 = fetch, 1 = load, 2 = store
    typedef struct {
        int          kind;
        logic [31:0] data;
    } done_t;
    done_t sb[$];

    task automatic push_exp(input int kind, input logic [31:0] data);
        done_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic take(input int kind, input logic [31:0] data);
        done_t e;
        if (sb.size() == 0) begin
            chk("unexpected_done", 64'(kind), 64'd99);
        end else begin
            e = sb.pop_front();
            chk("done_kind", 64'(kind), 64'(e.kind));
            chk("done_data", 64'(data), 64'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_rvalid) take(0, ifu_rdata);
            if (lsu_rvalid) begin
                take(1, lsu_rdata);
                chk("ifu_quiet_on_lsu", {31'd0, ifu_rvalid, ifu_rdata}, 64'd0);
            end
            if (lsu_wready) take(2, 32'd0);
        end
    end

    // ---------------- AXI slave model
    int          cfg_ar_dly, cfg_aw_dly, cfg_w_dly;
    logic [63:0] cfg_rdata;
    logic [1:0]  cfg_rresp, cfg_bresp;
    logic        cfg_r_hold;
    int          ar_cnt, aw_cnt, w_cnt;
    logic        aw_seen, w_seen;
    logic [31:0] cap_araddr, cap_awaddr;
    logic [2:0]  cap_arsize, cap_awsize;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_wlast;

    assign rlast = rvalid;

    always @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= '0;
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
        end else begin
            if (arvalid && arready) begin
                arready    <= 1'b0;
                ar_cnt     <= 0;
                cap_araddr <= araddr;
                cap_arsize <= arsize;
                if (!cfg_r_hold) begin
                    rvalid <= 1'b1;
                    rdata  <= cfg_rdata;
                    rresp  <= cfg_rresp;
                end
            end else if (arvalid) begin
                if (ar_cnt >= cfg_ar_dly) arready <= 1'b1;
                else ar_cnt <= ar_cnt + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;

            if (awvalid && awready) begin
                awready    <= 1'b0;
                aw_cnt     <= 0;
                cap_awaddr <= awaddr;
                cap_awsize <= awsize;
                aw_seen    <= 1'b1;
            end else if (awvalid) begin
                if (aw_cnt >= cfg_aw_dly) awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end

            if (wvalid && wready) begin
                wready    <= 1'b0;
                w_cnt     <= 0;
                cap_wdata <= wdata;
                cap_wstrb <= wstrb;
                cap_wlast <= wlast;
                w_seen    <= 1'b1;
            end else if (wvalid) begin
                if (w_cnt >= cfg_w_dly) wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end

            if (aw_seen && w_seen && !bvalid) begin
                bvalid  <= 1'b1;
                bresp   <= cfg_bresp;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    // ---------------- requester behaviour: hold each request until its done pulse
    task automatic run_reqs(input string tag);
        int cyc;
        cyc = 0;
        while ((ifu_arvalid || lsu_arvalid || lsu_wvalid) && cyc < 200) begin
            @(posedge clk);
            #1;
            if (ifu_rvalid) ifu_arvalid = 1'b0;
            if (lsu_rvalid) lsu_arvalid = 1'b0;
            if (lsu_wready) lsu_wvalid  = 1'b0;
            cyc++;
        end
        chk({tag, "_timeout"}, 64'(ifu_arvalid || lsu_arvalid || lsu_wvalid), 64'd0);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = '0;
        lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
        cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0;
        cfg_rdata = '0; cfg_rresp = 2'b00; cfg_bresp = 2'b00; cfg_r_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid",  64'(wvalid),  64'd0);
        chk("rst_rready",  64'(rready),  64'd0);
        chk("rst_bready",  64'(bready),  64'd0);
        chk("rst_done",    {61'd0, ifu_rvalid, lsu_rvalid, lsu_wready}, 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_araddr",  64'(araddr),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word fetch from the upper lane, slow arready
        cfg_ar_dly = 2;
        cfg_rdata  = 64'h11223344_55667788;
        push_exp(0, 32'h11223344);
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        run_reqs("fetch");
        chk("fetch_araddr", 64'(cap_araddr), 64'h8000_0004);
        chk("fetch_arsize", 64'(cap_arsize), 64'd2);
        chk("fetch_fixed",  {arid, arlen, 1'b0, arburst}, {4'd0, 8'd0, 1'b0, 2'b01});

        // Byte load, offset 3 in the lower lane
        cfg_ar_dly = 0;
        cfg_rdata  = 64'h0000_0000_AABB_CCDD;
        push_exp(1, 32'h0000_00AA);
        lsu_araddr = 32'h8000_0003; lsu_rstrb = 8'h01; lsu_arvalid = 1'b1;
        run_reqs("ld_byte");
        chk("ld_byte_arsize", 64'(cap_arsize), 64'd0);

        // Halfword load, offset 2 in the upper lane
        cfg_rdata = 64'hCAFE_BABE_DEAD_BEEF;
        push_exp(1, 32'h0000_CAFE);
        lsu_araddr = 32'h8000_0006; lsu_rstrb = 8'h03; lsu_arvalid = 1'b1;
        run_reqs("ld_half");
        chk("ld_half_arsize", 64'(cap_arsize), 64'd1);

        // Halfword store, AW accepted well before W
        cfg_aw_dly = 0; cfg_w_dly = 3;
        push_exp(2, 32'd0);
        lsu_awaddr = 32'h8000_0006; lsu_wdata = 32'h0000_1234; lsu_wstrb = 8'h03;
        lsu_wvalid = 1'b1;
        run_reqs("st_half");
        chk("st_half_wstrb",  64'(cap_wstrb), 64'hC0);
        chk("st_half_wdata",  cap_wdata, 64'h1234_0000_1234_0000);
        chk("st_half_awsize", 64'(cap_awsize), 64'd1);
        chk("st_half_awaddr", 64'(cap_awaddr), 64'h8000_0006);
        chk("st_half_wlast",  64'(cap_wlast), 64'd1);

        // Byte store, W accepted before AW
        cfg_aw_dly = 3; cfg_w_dly = 0;
        push_exp(2, 32'd0);
        lsu_awaddr = 32'h8000_0001; lsu_wdata = 32'h0000_00AB; lsu_wstrb = 8'h01;
        lsu_wvalid = 1'b1;
        run_reqs("st_byte");
        chk("st_byte_wstrb",  64'(cap_wstrb), 64'h02);
        chk("st_byte_wdata",  cap_wdata, 64'h0000_AB00_0000_AB00);
        chk("st_byte_awsize", 64'(cap_awsize), 64'd0);

        // All three requesters at once: store, then load, then fetch
        cfg_aw_dly = 1; cfg_w_dly = 1; cfg_ar_dly = 1;
        cfg_rdata  = 64'h0102_0304_0506_0708;
        push_exp(2, 32'd0);
        push_exp(1, 32'h0506_0708);
        push_exp(0, 32'h0102_0304);
        lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 8'h0f;
        lsu_araddr = 32'h8000_0008; lsu_rstrb = 8'h0f;
        ifu_araddr = 32'h8000_0004;
        lsu_wvalid = 1'b1; lsu_arvalid = 1'b1; ifu_arvalid = 1'b1;
        run_reqs("all3");
        chk("all3_wstrb",   64'(cap_wstrb), 64'h0F);
        chk("all3_wdata",   cap_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("all3_awaddr",  64'(cap_awaddr), 64'h8000_0010);
        chk("all3_last_ar", 64'(cap_araddr), 64'h8000_0004);

        // Requester drops its fetch mid-transaction: the done pulse still appears
        cfg_ar_dly = 3;
        cfg_rdata  = 64'h0000_0000_7654_3210;
        push_exp(0, 32'h7654_3210);
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("drop_sb_drained", 64'(sb.size()), 64'd0);

        // Error response on a read sets the sticky flag
        cfg_ar_dly = 0;
        cfg_rresp  = 2'b10;
        cfg_rdata  = 64'h0000_0000_0BAD_0BAD;
        push_exp(0, 32'h0BAD_0BAD);
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        run_reqs("rerr");
        chk("rerr_bus_err", 64'(bus_err), 64'd1);
        cfg_rresp = 2'b00;
        cfg_rdata = 64'h5555_0000_0000_0000;
        push_exp(0, 32'h5555_0000);
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        run_reqs("rok");
        chk("bus_err_sticky", 64'(bus_err), 64'd1);

        // Reset while waiting for read data: abandoned, no done pulse
        cfg_r_hold = 1'b1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        for (int i = 0; i < 30 && !rready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_in_rd_r", 64'(rready), 64'd1);
        rst = 1'b1; ifu_arvalid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_rready",  64'(rready),  64'd0);
        chk("rst_mid_bus_err", 64'(bus_err), 64'd0);
        chk("rst_mid_pulse",   64'(ifu_rvalid), 64'd0);
        rst = 1'b0; cfg_r_hold = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_arvalid", 64'(arvalid), 64'd0);
        chk("rst_mid_sb",      64'(sb.size()), 64'd0);

        // Error response on a write
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_bresp = 2'b11;
        push_exp(2, 32'd0);
        lsu_awaddr = 32'h8000_0020; lsu_wdata = 32'h1; lsu_wstrb = 8'h0f;
        lsu_wvalid = 1'b1;
        run_reqs("berr");
        chk("berr_bus_err", 64'(bus_err), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
